mole_responder: RTL
===================

Name: mole_responder

Overview:
- Automated player for the whack-a-mole game core; drives the opposite end of its button/mole interface.
- Watches the four mole outputs, waits a fixed reaction time, then pulses the matching hit (button) line for a fixed hold time.
- Counts hits issued and moles that escaped. Used for closed-loop self-test and demo mode in place of the physical buttons.

Parameters:
REACT_CYCLES, 5, cycles from mole sampled high to hit asserted (legal range 1..255)
HOLD_CYCLES, 3, cycles the hit line is held high (legal range 1..255)
CNT_W, 4, width of hits_sent and misses counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  responder active; low forces return to IDLE
mole  input  4  mole outputs from game core; bit0=mo1 ... bit3=mo4
hit  output  4  button drive to game core; bit0=in1 ... bit3=in4; at most one bit high
busy  output  1  high whenever state is not IDLE
hits_sent  output  CNT_W  completed hit pulses, wraps modulo 2^CNT_W
misses  output  CNT_W  moles that dropped before the hit fired, wraps modulo 2^CNT_W

Behaviour:
- All outputs registered. Reset (rst high at an edge): state=IDLE, hit=0, busy=0, hits_sent=0, misses=0, internal target=0, cnt=0. Reset overrides every other condition, including mid-WAIT and mid-PRESS.
- States: IDLE, WAIT, PRESS, COOLDOWN.
- IDLE: at an edge with enable=1 and mole!=0:
  - target <= one-hot of the lowest set bit of mole (simultaneous moles: lowest index wins).
  - cnt <= 0; state -> WAIT.
- WAIT: evaluated at each edge, in priority order:
  - (mole & target)==0 -> IDLE, misses+1 (escape). Escape takes priority even on the final reaction edge.
  - cnt==REACT_CYCLES-1 -> PRESS, hit<=target, cnt<=0.
  - Otherwise cnt+1.
- Latency: mole sampled high at edge E0 gives hit high after edge E0+REACT_CYCLES.
- PRESS: hit held at target regardless of mole.
  - At the edge where cnt==HOLD_CYCLES-1: hit<=0, hits_sent+1, state -> COOLDOWN. Otherwise cnt+1.
  - Hit is high for exactly HOLD_CYCLES cycles.
- COOLDOWN: hit=0.
  - At an edge with (mole & target)==0 -> IDLE, target<=0.
  - Prevents re-hitting the same mole appearance. No timeout; a stuck mole holds COOLDOWN until enable drops.
- enable=0 sampled in any state:
  - Next state is IDLE, hit<=0, target<=0.
  - No counter increments on that edge, including an aborted PRESS.
  - Counters otherwise hold their values.
- IDLE with enable=1 and mole=0: stays IDLE.
- A new mole while in WAIT, PRESS or COOLDOWN is ignored. It is considered only after the return to IDLE, if it is still high at that point.
- busy = (state != IDLE), registered alongside state.
- Counters wrap: with CNT_W=4, 15+1 -> 0.

Test Plan:
1. Defaults, enable=1. mole=4'b0001 raised after edge 10 and held -> hit=4'b0001 high for exactly 3 cycles, starting after edge 16 (sampled at edge 11, +5). hits_sent=1. busy high from after edge 11 until mole drops. hit stays 0 while the mole remains high.
2. mole=4'b0100 held for 3 cycles only -> escape in WAIT. hit never asserted, misses=1, hits_sent unchanged, return to IDLE.
3. mole=4'b1010 simultaneous -> hit=4'b0010 only. Clear bit1 while keeping bit3 high -> after COOLDOWN exits, a second pulse hit=4'b1000 occurs; hits_sent=2.
4. rst=1 for one edge during PRESS, hit=4'b0100 -> hit=0, busy=0, hits_sent=0, misses=0 after that edge. No further pulse until a new mole is sampled.
5. enable dropped during PRESS -> hit=0 after the next edge, state IDLE, hits_sent not incremented. Re-enable with the mole still high -> a full new reaction delay of 5 cycles, then a 3-cycle pulse.
6. 16 back-to-back complete hit cycles -> hits_sent wraps 15 -> 0. hit never has more than one bit set throughout.

Source files
------------

// File: rtl/mole_responder.sv
// Automated whack-a-mole player.
// Watches the four mole lines. After a fixed reaction time it pulses the
// matching hit line for a fixed hold time. It also counts issued hits and
// moles that escaped before the hit fired.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   enable_i     responder active; low forces a return to idle
//   mole_i[3:0]  mole outputs from the game core (bit0 = mo1)
//   hit_o[3:0]   button drive to the game core (bit0 = in1); at most one bit set
//   busy_o       high whenever the responder is not idle
//   hits_sent_o  completed hit pulses, wraps
//   misses_o     moles that dropped before the hit fired, wraps
module mole_responder #(
  parameter int unsigned REACT_CYCLES = 5,
  parameter int unsigned HOLD_CYCLES  = 3,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [3:0]       mole_i,
  output logic [3:0]       hit_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] hits_sent_o,
  output logic [CNT_W-1:0] misses_o
);

  localparam logic [7:0] ReactLast = 8'(REACT_CYCLES - 1);
  localparam logic [7:0] HoldLast  = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StPress, StCooldown} state_e;

  state_e           state_q, state_d;
  logic [3:0]       target_q, target_d;
  logic [3:0]       hit_q, hit_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] misses_q, misses_d;
  logic             busy_q, busy_d;

  // The targeted mole is still up.
  logic target_up;
  assign target_up = |(mole_i & target_q);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    hit_d    = hit_q;
    cnt_d    = cnt_q;
    hits_d   = hits_q;
    misses_d = misses_q;

    if (!enable_i) begin
      // Abort from any state; counters hold, even for an interrupted press.
      state_d  = StIdle;
      hit_d    = 4'b0000;
      target_d = 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mole_i != 4'b0000) begin
            // Isolate the lowest set bit so simultaneous moles pick the lowest index.
            target_d = mole_i & (~mole_i + 4'd1);
            cnt_d    = 8'd0;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (!target_up) begin
            // Escape wins even on the final reaction edge.
            state_d  = StIdle;
            misses_d = misses_q + CNT_W'(1);
          end else if (cnt_q == ReactLast) begin
            state_d = StPress;
            hit_d   = target_q;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StPress: begin
          if (cnt_q == HoldLast) begin
            hit_d   = 4'b0000;
            hits_d  = hits_q + CNT_W'(1);
            state_d = StCooldown;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StCooldown: begin
          // Wait for this appearance to go away so it is not hit twice.
          if (!target_up) begin
            state_d  = StIdle;
            target_d = 4'b0000;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      target_q <= 4'b0000;
      hit_q    <= 4'b0000;
      cnt_q    <= 8'd0;
      hits_q   <= '0;
      misses_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      busy_q   <= busy_d;
    end
  end

  assign hit_o       = hit_q;
  assign busy_o      = busy_q;
  assign hits_sent_o = hits_q;
  assign misses_o    = misses_q;

endmodule
